// File: rtl/mld_15_7_decoder_pkg.sv
// Shared constants, types and the syndrome shift function for the (15,7) majority-logic decoder.
package mld_15_7_decoder_pkg;

    localparam int unsigned N  = 15;
    localparam int unsigned K  = 7;
    localparam int unsigned NK = N - K;

    // g(x) = 1 + x^4 + x^6 + x^7 + x^8, bit i holds the coefficient of x^i
    localparam logic [NK:0] GenMask = 9'b1_1101_0001;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDecode
    } state_e;

    // Operation requested of the syndrome register in a given cycle
    typedef enum logic [1:0] {
        SynHold,
        SynClear,
        SynStart,
        SynShift
    } syn_op_e;

    // s' = x*s mod g(x) + din; the input enters at x^0 and the taps see only s7
    function automatic logic [NK-1:0] syn_shift(input logic [NK-1:0] s, input logic din);
        logic [NK-1:0] r;
        r    = {s[NK-2:0], 1'b0} ^ ({NK{s[NK-1]}} & GenMask[NK-1:0]);
        r[0] = r[0] ^ din;
        return r;
    endfunction

endpackage

// File: rtl/mld_15_7_syndrome_unit.sv
// Syndrome register with feedback, four orthogonal check sums and the majority gate.
module mld_15_7_syndrome_unit
    import mld_15_7_decoder_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  syn_op_e op,
    input  logic    din,
    input  logic    corr_en,
    output logic    maj
);

    logic [NK-1:0] syn_q, syn_d;
    logic          a1, a2, a3, a4;
    logic [2:0]    votes;

    // Check sums orthogonal on the buffer head, and the majority vote over them
    always_comb begin
        a1    = syn_q[7];
        a2    = syn_q[3];
        a3    = syn_q[0] ^ syn_q[2] ^ syn_q[6];
        a4    = syn_q[1] ^ syn_q[5];
        votes = 3'(a1) + 3'(a2) + 3'(a3) + 3'(a4);
        maj   = corr_en & (votes >= 3'd3);
    end

    // Next syndrome value for the requested operation
    always_comb begin
        syn_d = syn_q;
        case (op)
            SynHold:  syn_d = syn_q;
            SynClear: syn_d = '0;
            SynStart: syn_d = syn_shift('0, din);
            SynShift: syn_d = syn_shift(syn_q, din);
            default:  syn_d = syn_q;
        endcase
    end

    // Syndrome register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syn_q <= '0;
        end else begin
            syn_q <= syn_d;
        end
    end

endmodule

// File: rtl/mld_15_7_decoder.sv
// Serial Type-I majority-logic decoder for the (15,7) cyclic code, r14 first in and out.
module mld_15_7_decoder
    import mld_15_7_decoder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic received_bit_stream,
    input  logic correct_errors,
    output logic decoded_bit_stream
);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    buf_q, buf_d;
    logic            corr_en_q, corr_en_d;
    logic            dec_q, dec_d;
    syn_op_e         syn_op;
    logic            syn_din;
    logic            maj;

    mld_15_7_syndrome_unit u_syndrome (
        .clk     (clk),
        .reset   (reset),
        .op      (syn_op),
        .din     (syn_din),
        .corr_en (corr_en_q),
        .maj     (maj)
    );

    // FSM next state, buffer/counter updates, syndrome control and output bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        corr_en_d = corr_en_q;
        dec_d     = 1'b0;
        syn_op    = SynHold;
        syn_din   = 1'b0;

        case (state_q)
            StIdle: begin
                if (load) begin
                    buf_d     = {buf_q[N-2:0], received_bit_stream};
                    syn_op    = SynStart;
                    syn_din   = received_bit_stream;
                    corr_en_d = correct_errors;
                    cnt_d     = CntW'(1);
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (load) begin
                    buf_d     = {buf_q[N-2:0], received_bit_stream};
                    syn_op    = SynShift;
                    syn_din   = received_bit_stream;
                    corr_en_d = correct_errors;
                    if (cnt_q == CntW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = StDecode;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    // Short block: drop it and start over
                    syn_op  = SynClear;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            StDecode: begin
                dec_d   = buf_q[N-1] ^ maj;
                syn_op  = SynShift;
                syn_din = maj;
                buf_d   = {buf_q[N-2:0], 1'b0};
                if (cnt_q == CntW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, buffer, counter, correction flag and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            buf_q     <= '0;
            corr_en_q <= 1'b0;
            dec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            corr_en_q <= corr_en_d;
            dec_q     <= dec_d;
        end
    end

    assign decoded_bit_stream = dec_q;

endmodule

// File: tb/tb_mld_15_7_decoder.sv
// Directed self-checking bench for mld_15_7_decoder.
module tb_mld_15_7_decoder;

    logic clk;
    logic reset;
    logic load;
    logic received_bit_stream;
    logic correct_errors;
    logic decoded_bit_stream;

    int n_cmp = 0;
    int n_err = 0;

    // Blocks are written r14 (first bit on the wire) as the MSB
    localparam logic [14:0] CodeWord  = 15'b100000011101000;
    localparam logic [14:0] DblErr    = 15'b100010011101010;  // errors at r10 and r1
    localparam logic [14:0] SingleErr = 15'b000000011101000;  // error at r14
    localparam logic [14:0] Zero      = 15'b000000000000000;

    mld_15_7_decoder dut (
        .clk                 (clk),
        .reset               (reset),
        .load                (load),
        .received_bit_stream (received_bit_stream),
        .correct_errors      (correct_errors),
        .decoded_bit_stream  (decoded_bit_stream)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive 'count' bits of a block, r14 first; correct_errors differs on the last load edge
    task automatic load_bits(input logic [14:0] bits, input int count, input logic ce_rest,
                             input logic ce_last, input string tag);
        for (int i = 0; i < count; i++) begin
            load                = 1'b1;
            received_bit_stream = bits[14-i];
            correct_errors      = (i == count - 1) ? ce_last : ce_rest;
            @(posedge clk);
            #1;
            check($sformatf("%s_load%0d", tag, i), decoded_bit_stream, 1'b0);
        end
        load                = 1'b0;
        received_bit_stream = 1'b0;
        // Must not matter outside load edges
        correct_errors      = ~ce_last;
    endtask

    task automatic check_out(input logic [14:0] exp, input int count, input string tag);
        for (int i = 0; i < count; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_out%0d", tag, i), decoded_bit_stream, exp[14-i]);
        end
    endtask

    task automatic run_block(input logic [14:0] bits, input logic ce_rest, input logic ce_last,
                             input logic [14:0] exp, input string tag);
        load_bits(bits, 15, ce_rest, ce_last, tag);
        check_out(exp, 15, tag);
        @(posedge clk);
        #1;
        check($sformatf("%s_tail", tag), decoded_bit_stream, 1'b0);
    endtask

    initial begin
        reset               = 1'b0;
        load                = 1'b0;
        received_bit_stream = 1'b0;
        correct_errors      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", decoded_bit_stream, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_out", decoded_bit_stream, 1'b0);

        // Double error corrected
        run_block(DblErr, 1'b1, 1'b1, CodeWord, "dbl");
        // Correction disabled on the last load edge only: raw stream comes out
        run_block(DblErr, 1'b1, 1'b0, DblErr, "raw");
        // Single error in the first bit
        run_block(SingleErr, 1'b1, 1'b1, CodeWord, "single");
        // Clean codeword and all-zero block pass through
        run_block(CodeWord, 1'b1, 1'b1, CodeWord, "clean");
        run_block(Zero, 1'b1, 1'b1, Zero, "zero");

        // Short block of 7 bits is discarded
        load_bits(DblErr, 7, 1'b1, 1'b1, "short");
        check_out(Zero, 15, "short");
        run_block(SingleErr, 1'b1, 1'b1, CodeWord, "after_short");

        // Reset in the middle of decoding
        load_bits(DblErr, 15, 1'b1, 1'b1, "mid");
        check_out(CodeWord, 5, "mid");
        reset = 1'b0;
        #2;
        check("mid_reset_now", decoded_bit_stream, 1'b0);
        @(posedge clk);
        #1;
        check("mid_reset_held", decoded_bit_stream, 1'b0);
        #3;
        reset = 1'b1;
        run_block(DblErr, 1'b1, 1'b1, CodeWord, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
